// File: rtl/lii_stream_rr_arbiter.sv
// lii_stream_rr_arbiter
//   Packet-granular round-robin arbiter merging N LII streams into one
//   registered output stream. A grant is held from the first beat of a packet
//   through its s_last beat, so packets from different inputs never
//   interleave. Arbitration restarts the cycle after a packet's last beat.
//
// Ports
//   clk      clock
//   rstn     asynchronous active-low reset
//   s_data   N*DW      input data, slice i = [i*DW +: DW]
//   s_keep   N*DW/8    input keep, sliced per input
//   s_strb   N*DW/8    input strobe, sliced per input
//   s_last   N         last beat of packet, per input
//   s_src    N*SRC_W   source id, sliced per input
//   s_dst    N*DST_W   destination id, sliced per input
//   s_type   N*TYPE_W  packet type, sliced per input
//   s_valid  N         per-input valid
//   s_ready  N         per-input ready (combinational, at most one set)
//   m_*      merged output stream fields (registered)
//   m_sel    GW        index of the input that produced the current m_* beat
//   m_valid  output valid (registered)
//   m_ready  output ready
module lii_stream_rr_arbiter #(
    parameter int N      = 4,
    parameter int DW     = 256,
    parameter int SRC_W  = 8,
    parameter int DST_W  = 8,
    parameter int TYPE_W = 2,
    localparam int GW    = (N <= 1) ? 1 : $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [N*DW-1:0]       s_data,
    input  logic [N*(DW/8)-1:0]   s_keep,
    input  logic [N*(DW/8)-1:0]   s_strb,
    input  logic [N-1:0]          s_last,
    input  logic [N*SRC_W-1:0]    s_src,
    input  logic [N*DST_W-1:0]    s_dst,
    input  logic [N*TYPE_W-1:0]   s_type,
    input  logic [N-1:0]          s_valid,
    output logic [N-1:0]          s_ready,
    output logic [DW-1:0]         m_data,
    output logic [DW/8-1:0]       m_keep,
    output logic [DW/8-1:0]       m_strb,
    output logic                  m_last,
    output logic [SRC_W-1:0]      m_src,
    output logic [DST_W-1:0]      m_dst,
    output logic [TYPE_W-1:0]     m_type,
    output logic [GW-1:0]         m_sel,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int KW = DW / 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [GW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [GW-1:0]   grant_reg, grant_next;
    logic [GW-1:0]   winner;
    logic [GW-1:0]   sel;
    logic            any_valid;
    logic            load_en;
    logic            xfer;

    // Per-input views of the flattened input buses.
    logic [DW-1:0]     data_arr [N];
    logic [KW-1:0]     keep_arr [N];
    logic [KW-1:0]     strb_arr [N];
    logic [SRC_W-1:0]  src_arr  [N];
    logic [DST_W-1:0]  dst_arr  [N];
    logic [TYPE_W-1:0] type_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign data_arr[gi] = s_data[gi*DW +: DW];
            assign keep_arr[gi] = s_keep[gi*KW +: KW];
            assign strb_arr[gi] = s_strb[gi*KW +: KW];
            assign src_arr[gi]  = s_src[gi*SRC_W +: SRC_W];
            assign dst_arr[gi]  = s_dst[gi*DST_W +: DST_W];
            assign type_arr[gi] = s_type[gi*TYPE_W +: TYPE_W];
        end
    endgenerate

    // The output register can accept a beat when empty or being drained.
    assign load_en = !m_valid || m_ready;

    // Round-robin search: start just after the last packet's winner and wrap,
    // so the input granted most recently has the lowest priority.
    always_comb begin
        logic [GW-1:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = GW'((int'(rr_ptr_reg) + k) % N);
            if (!any_valid && s_valid[idx]) begin
                winner    = idx;
                any_valid = 1'b1;
            end
        end
    end

    // While a packet is in flight only its owner is served; otherwise the
    // round-robin winner is. s_ready never looks at the owner's own valid.
    always_comb begin
        state_next  = state_reg;
        rr_ptr_next = rr_ptr_reg;
        grant_next  = grant_reg;
        s_ready     = '0;
        sel         = (state_reg == LOCKED) ? grant_reg : winner;
        if (rstn && load_en && ((state_reg == LOCKED) || any_valid)) begin
            s_ready[sel] = 1'b1;
        end
        xfer = s_valid[sel] && s_ready[sel];
        case (state_reg)
            IDLE: begin
                if (xfer) begin
                    rr_ptr_next = sel;
                    grant_next  = sel;
                    if (!s_last[sel]) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (xfer && s_last[sel]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= GW'(N - 1);
            grant_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            rr_ptr_reg <= rr_ptr_next;
            grant_reg  <= grant_next;
        end
    end

    // Output register: a transferred beat appears on m_* the next cycle and
    // holds while the downstream stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
            m_strb  <= '0;
            m_last  <= 1'b0;
            m_src   <= '0;
            m_dst   <= '0;
            m_type  <= '0;
            m_sel   <= '0;
        end else if (load_en) begin
            m_valid <= xfer;
            if (xfer) begin
                m_data <= data_arr[sel];
                m_keep <= keep_arr[sel];
                m_strb <= strb_arr[sel];
                m_last <= s_last[sel];
                m_src  <= src_arr[sel];
                m_dst  <= dst_arr[sel];
                m_type <= type_arr[sel];
                m_sel  <= sel;
            end
        end
    end

endmodule

// File: tb/tb_lii_stream_rr_arbiter.sv
// Testbench for lii_stream_rr_arbiter (N=4, DW=32). Per-input beat queues
// feed the DUT; a packet-level model predicts grants, s_ready and the output
// register each cycle, and a per-input scoreboard checks that every beat
// leaves exactly once and in order.
module tb_lii_stream_rr_arbiter;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int KW     = DW / 8;
    localparam int SRC_W  = 8;
    localparam int DST_W  = 8;
    localparam int TYPE_W = 2;
    localparam int GW     = 2;

    typedef struct packed {
        logic [DW-1:0]     data;
        logic [KW-1:0]     keep;
        logic [KW-1:0]     strb;
        logic              last;
        logic [SRC_W-1:0]  src;
        logic [DST_W-1:0]  dst;
        logic [TYPE_W-1:0] typ;
    } beat_t;

    logic                 clk;
    logic                 rstn;
    logic [N*DW-1:0]      s_data;
    logic [N*KW-1:0]      s_keep;
    logic [N*KW-1:0]      s_strb;
    logic [N-1:0]         s_last;
    logic [N*SRC_W-1:0]   s_src;
    logic [N*DST_W-1:0]   s_dst;
    logic [N*TYPE_W-1:0]  s_type;
    logic [N-1:0]         s_valid;
    logic [N-1:0]         s_ready;
    logic [DW-1:0]        m_data;
    logic [KW-1:0]        m_keep;
    logic [KW-1:0]        m_strb;
    logic                 m_last;
    logic [SRC_W-1:0]     m_src;
    logic [DST_W-1:0]     m_dst;
    logic [TYPE_W-1:0]    m_type;
    logic [GW-1:0]        m_sel;
    logic                 m_valid;
    logic                 m_ready;

    lii_stream_rr_arbiter #(
        .N(N), .DW(DW), .SRC_W(SRC_W), .DST_W(DST_W), .TYPE_W(TYPE_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .s_data(s_data), .s_keep(s_keep), .s_strb(s_strb), .s_last(s_last),
        .s_src(s_src), .s_dst(s_dst), .s_type(s_type),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_strb(m_strb), .m_last(m_last),
        .m_src(m_src), .m_dst(m_dst), .m_type(m_type),
        .m_sel(m_sel), .m_valid(m_valid), .m_ready(m_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_chk  = 0;
    int    n_fail = 0;
    beat_t q  [N][$];      // beats waiting to be offered on each input
    beat_t sb [N][$];      // beats each input still owes the output
    bit    en [N];         // per-input valid gating
    int    log_sel [$];
    logic [DW-1:0] log_data [$];
    int    seq_cnt = 0;

    // Model state: pointer, packet ownership and the expected output register.
    int    mdl_ptr, mdl_grant, exp_sel;
    bit    mdl_locked, exp_valid;
    beat_t exp_beat;
    int    nxt_ptr, nxt_grant, nxt_sel, pop_idx;
    bit    nxt_locked, nxt_valid;
    beat_t nxt_beat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            beat_t b;
            b = '0;
            if (q[i].size() > 0) b = q[i][0];
            s_valid[i]                  = en[i] && (q[i].size() > 0);
            s_data[i*DW +: DW]          = b.data;
            s_keep[i*KW +: KW]          = b.keep;
            s_strb[i*KW +: KW]          = b.strb;
            s_last[i]                   = b.last;
            s_src[i*SRC_W +: SRC_W]     = b.src;
            s_dst[i*DST_W +: DST_W]     = b.dst;
            s_type[i*TYPE_W +: TYPE_W]  = b.typ;
        end
    endtask

    task automatic add_beat(input int i, input logic [DW-1:0] data, input bit last);
        beat_t b;
        b.data = data;
        b.keep = KW'($urandom);
        b.strb = KW'($urandom);
        b.last = last;
        b.src  = SRC_W'($urandom);
        b.dst  = DST_W'($urandom);
        b.typ  = TYPE_W'($urandom);
        q[i].push_back(b);
        sb[i].push_back(b);
    endtask

    task automatic add_pkt(input int i, input int len);
        for (int k = 0; k < len; k++) begin
            add_beat(i, {8'(i), 24'(seq_cnt)}, k == len - 1);
            seq_cnt++;
        end
    endtask

    // Priority of a requester is its distance past the pointer; nearest wins.
    function automatic int pick(input bit le);
        int best, bestd;
        best  = -1;
        bestd = N;
        if (!le) return -1;
        if (mdl_locked) return mdl_grant;
        for (int i = 0; i < N; i++) begin
            if (s_valid[i]) begin
                int d;
                d = (i - mdl_ptr - 1 + 2 * N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    // Model + compare process: evaluate on the falling edge, commit on the
    // rising edge, then present the next input beats.
    initial begin : model
        beat_t got;
        logic [N-1:0] exp_rdy;
        bit le, xfer;
        int p, s;
        forever begin
            @(negedge clk);
            got = {m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type};
            if (!rstn) begin
                chk("rst_m_valid", 64'(m_valid), 64'(0));
                chk("rst_m_fields", 64'(got), 64'(0));
                chk("rst_m_sel", 64'(m_sel), 64'(0));
                chk("rst_s_ready", 64'(s_ready), 64'(0));
                mdl_ptr = N - 1; mdl_locked = 0; mdl_grant = 0;
                exp_valid = 0; exp_beat = '0; exp_sel = 0;
                nxt_ptr = N - 1; nxt_locked = 0; nxt_grant = 0;
                nxt_valid = 0; nxt_beat = '0; nxt_sel = 0;
                pop_idx = -1;
            end else begin
                le = !exp_valid || m_ready;
                p  = pick(le);
                exp_rdy = '0;
                if (p >= 0) exp_rdy = N'(1) << p;
                chk("s_ready", 64'(s_ready), 64'(exp_rdy));
                chk("m_valid", 64'(m_valid), 64'(exp_valid));
                if (exp_valid) begin
                    chk("m_beat", 64'(got), 64'(exp_beat));
                    chk("m_sel", 64'(m_sel), 64'(exp_sel));
                end
                if (m_valid && m_ready) begin
                    s = int'(m_sel);
                    $display("beat out: in=%0d data=%h last=%0b", s, m_data, m_last);
                    log_sel.push_back(s);
                    log_data.push_back(m_data);
                    chk("sb_nonempty", 64'(sb[s].size() > 0), 64'(1));
                    if (sb[s].size() > 0) chk("sb_beat", 64'(got), 64'(sb[s].pop_front()));
                end
                xfer = (p >= 0) && s_valid[p];
                nxt_ptr = mdl_ptr; nxt_grant = mdl_grant; nxt_locked = mdl_locked;
                nxt_valid = exp_valid; nxt_beat = exp_beat; nxt_sel = exp_sel;
                pop_idx = -1;
                if (le) nxt_valid = xfer;
                if (xfer && q[p].size() > 0) begin
                    nxt_beat = q[p][0];
                    nxt_sel  = p;
                    pop_idx  = p;
                    if (!mdl_locked) begin
                        nxt_ptr    = p;
                        nxt_grant  = p;
                        nxt_locked = !q[p][0].last;
                    end else if (q[p][0].last) begin
                        nxt_locked = 0;
                    end
                end
            end
            @(posedge clk);
            mdl_ptr = nxt_ptr; mdl_grant = nxt_grant; mdl_locked = nxt_locked;
            exp_valid = nxt_valid; exp_beat = nxt_beat; exp_sel = nxt_sel;
            #1;
            if (pop_idx >= 0 && q[pop_idx].size() > 0) void'(q[pop_idx].pop_front());
            drive();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_en(input bit v);
        for (int i = 0; i < N; i++) en[i] = v;
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        set_en(1'b1);
        m_ready = 1'b1;
        drive();
        while (k < bound && !(all_empty() && !exp_valid)) begin
            tick();
            k++;
        end
        chk("drain_in_time", 64'(k < bound), 64'(1));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base;
        beat_t hold;
        logic [GW-1:0] hold_sel;

        rstn    = 1'b1;
        m_ready = 1'b1;
        set_en(1'b1);
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) add_pkt(i, 1);
        drive();
        #1 rstn = 1'b0;

        // Reset held with every input valid.
        repeat (3) tick();
        @(negedge clk);
        chk("t1_rst_s_ready", 64'(s_ready), 64'(0));
        chk("t1_rst_m_valid", 64'(m_valid), 64'(0));

        // Release: input 0 first, output valid one cycle after the transfer.
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("t1_first_ready", 64'(s_ready), 64'(4'b0001));
        chk("t1_m_valid_lat0", 64'(m_valid), 64'(0));
        @(negedge clk);
        chk("t1_m_valid_lat1", 64'(m_valid), 64'(1));
        chk("t1_first_sel", 64'(m_sel), 64'(0));
        tick();
        drain(200);
        for (int k = 0; k < 12; k++) chk("t2_rr_order", 64'(log_sel[k]), 64'(k % 4));

        // Multi-beat packet on input 1, input 0 arrives after its first beat.
        drain(200);
        base = log_sel.size();
        add_beat(1, 32'hA1, 0);
        add_beat(1, 32'hA2, 0);
        add_beat(1, 32'hA3, 1);
        drive();
        tick();
        add_beat(0, 32'hB0, 1);
        drive();
        @(negedge clk);
        chk("t3_in0_blocked", 64'(s_ready[0]), 64'(0));
        repeat (6) tick();
        chk("t3_d0", 64'(log_data[base]),     64'(32'hA1));
        chk("t3_d1", 64'(log_data[base + 1]), 64'(32'hA2));
        chk("t3_d2", 64'(log_data[base + 2]), 64'(32'hA3));
        chk("t3_d3", 64'(log_data[base + 3]), 64'(32'hB0));
        chk("t3_s0", 64'(log_sel[base]),      64'(1));
        chk("t3_s2", 64'(log_sel[base + 2]),  64'(1));
        chk("t3_s3", 64'(log_sel[base + 3]),  64'(0));

        // Output stall for five cycles, then random traffic and backpressure.
        drain(200);
        for (int i = 0; i < N; i++) begin
            add_pkt(i, $urandom_range(1, 4));
            add_pkt(i, $urandom_range(1, 4));
        end
        drive();
        repeat (3) tick();
        m_ready = 1'b0;
        @(negedge clk);
        chk("t4_stall_valid", 64'(m_valid), 64'(1));
        hold     = {m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type};
        hold_sel = m_sel;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t4_stall_beat", 64'({m_data, m_keep, m_strb, m_last, m_src, m_dst, m_type}), 64'(hold));
            chk("t4_stall_sel", 64'(m_sel), 64'(hold_sel));
            chk("t4_stall_ready", 64'(s_ready), 64'(0));
        end
        tick();
        m_ready = 1'b1;
        for (int c = 0; c < 150; c++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) add_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
            drive();
            tick();
        end
        drain(500);

        // Lone requester granted back-to-back, then the pointer wraps 3 -> 0.
        base = log_sel.size();
        for (int k = 0; k < 5; k++) add_pkt(2, 1);
        drive();
        repeat (7) tick();
        chk("t5_count", 64'(log_sel.size() - base), 64'(5));
        for (int k = 0; k < 5; k++) chk("t5_sel2", 64'(log_sel[base + k]), 64'(2));
        add_pkt(0, 1);
        add_pkt(3, 1);
        drive();
        repeat (4) tick();
        chk("t5_wrap_first", 64'(log_sel[base + 5]), 64'(3));
        chk("t5_wrap_second", 64'(log_sel[base + 6]), 64'(0));

        // Reset in the middle of a 4-beat packet.
        drain(200);
        add_pkt(3, 4);
        drive();
        tick();
        tick();
        rstn = 1'b0;
        q[3].delete();
        sb[3].delete();
        drive();
        @(negedge clk);
        chk("t6_abort_m_valid", 64'(m_valid), 64'(0));
        tick();
        tick();
        rstn = 1'b1;
        base = log_sel.size();
        for (int i = 0; i < N; i++) add_pkt(i, 1);
        drive();
        repeat (8) tick();
        for (int k = 0; k < N; k++) chk("t6_post_rst_order", 64'(log_sel[base + k]), 64'(k));

        drain(200);
        for (int i = 0; i < N; i++) chk("final_sb_empty", 64'(sb[i].size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
